// File: rtl/regfile_param.sv
// regfile_param: parameterised register file with two combinational read
// ports, one synchronous write port and a clear sweep that zeroes one entry
// per cycle.
// ZERO_REG=1 hardwires entry 0 to zero.
// Optional feature: define REGFILE_BYPASS_EN to forward write data to a read
// port that addresses the entry being written in the same cycle. Without the
// macro, a read shows the stored value and sees the new data one cycle later.
module regfile_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                  clock,
  input  logic                  ctrl_reset_n,
  input  logic                  ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB,
  input  logic                  ctrl_clear,
  output logic                  clear_busy,
  output logic                  clear_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // Index of the last entry. The counter is compared against this value
  // instead of DEPTH, so the check never needs a wider counter.
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic                  wr_ok;

  // Writes are accepted only while idle. Writes to entry 0 are dropped when
  // that entry is hardwired to zero.
  assign wr_ok = ctrl_writeEnable && (state_q == IDLE) &&
                 !((ZERO_REG != 1'b0) && (ctrl_writeReg == '0));

  // Next-state logic for the sweep FSM and its entry counter.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave a value unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (ctrl_clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next array contents. A write and a clear request on the same idle edge
  // both take effect, because the sweep clears entries only in later cycles.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_ok) begin
      mem_d[ctrl_writeReg] = data_writeReg;
    end
    if (state_q == CLEAR) begin
      mem_d[cnt_q] = '0;
    end
  end

  // State, counter and array registers. Reset clears all of them
  // asynchronously, which also aborts any sweep in progress.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      // NOTE: the array is built from flops with a reset, because every entry must read zero directly after reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments update all registers together at the clock edge, so no register reads another register's new value.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Read port A: value from the array, optional forwarding, zero register.
  always_comb begin
    data_readRegA = mem_q[ctrl_readRegA];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (ctrl_readRegA == ctrl_writeReg)) begin
      data_readRegA = data_writeReg;
    end
`endif
    if ((ZERO_REG != 1'b0) && (ctrl_readRegA == '0)) begin
      data_readRegA = '0;
    end
  end

  // Read port B: same rules as port A, evaluated independently.
  always_comb begin
    data_readRegB = mem_q[ctrl_readRegB];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (ctrl_readRegB == ctrl_writeReg)) begin
      data_readRegB = data_writeReg;
    end
`endif
    if ((ZERO_REG != 1'b0) && (ctrl_readRegB == '0)) begin
      data_readRegB = '0;
    end
  end

  assign clear_busy = (state_q == CLEAR);
  assign clear_done = (state_q == DONE);

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: scoreboard bench for regfile_param. Two instances share
// the same stimulus: inst0 has ZERO_REG=1 and inst1 has ZERO_REG=0. The
// driver pushes the expected outputs of each cycle into a queue. A monitor
// pops one entry on each falling clock edge and compares it with the outputs.
module tb_regfile_param;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clock;
  logic          ctrl_reset_n;
  logic          ctrl_writeEnable;
  logic [AW-1:0] ctrl_writeReg;
  logic [DW-1:0] data_writeReg;
  logic [AW-1:0] ctrl_readRegA;
  logic [AW-1:0] ctrl_readRegB;
  logic          ctrl_clear;
  logic [DW-1:0] rd_a0, rd_b0, rd_a1, rd_b1;
  logic          busy0, done0, busy1, done1;

  regfile_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b1)) u_dut0 (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .ctrl_readRegA(ctrl_readRegA),
    .ctrl_readRegB(ctrl_readRegB), .data_readRegA(rd_a0),
    .data_readRegB(rd_b0), .ctrl_clear(ctrl_clear),
    .clear_busy(busy0), .clear_done(done0)
  );

  regfile_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b0)) u_dut1 (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .ctrl_readRegA(ctrl_readRegA),
    .ctrl_readRegB(ctrl_readRegB), .data_readRegA(rd_a1),
    .data_readRegB(rd_b1), .ctrl_clear(ctrl_clear),
    .clear_busy(busy1), .clear_done(done1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] a0, b0, a1, b1;
    logic          busy, done;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: the stored contents of both instances. sweep_pos is -1
  // when no sweep is running, 0..DEPTH-1 while the sweep is at that entry,
  // and DEPTH during the completion cycle.
  logic [DW-1:0] model_mem [2][DEPTH];
  int            sweep_pos;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int z = 0; z < 2; z++)
      for (int i = 0; i < DEPTH; i++) model_mem[z][i] = '0;
    sweep_pos = -1;
  endfunction

  // z=0 is the ZERO_REG=1 instance; z=1 is the ZERO_REG=0 instance.
  function automatic logic [DW-1:0] model_read(input int z, input logic [AW-1:0] addr);
    if (!ctrl_reset_n) return '0;
    if (z == 0 && addr == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (ctrl_writeEnable && sweep_pos < 0 && addr == ctrl_writeReg &&
        !(z == 0 && ctrl_writeReg == 0)) return data_writeReg;
`endif
    return model_mem[z][addr];
  endfunction

  // Effect of one rising edge, applied to the inputs present at that edge.
  function automatic void model_edge();
    if (!ctrl_reset_n) return;
    if (sweep_pos < 0) begin
      for (int z = 0; z < 2; z++)
        if (ctrl_writeEnable && !(z == 0 && ctrl_writeReg == 0))
          model_mem[z][ctrl_writeReg] = data_writeReg;
      if (ctrl_clear) sweep_pos = 0;
    end else if (sweep_pos < DEPTH) begin
      for (int z = 0; z < 2; z++) model_mem[z][sweep_pos] = '0;
      sweep_pos++;
    end else begin
      sweep_pos = -1;
    end
  endfunction

  function automatic void push_expect();
    exp_t e;
    e.a0   = model_read(0, ctrl_readRegA);
    e.b0   = model_read(0, ctrl_readRegB);
    e.a1   = model_read(1, ctrl_readRegA);
    e.b1   = model_read(1, ctrl_readRegB);
    e.busy = ctrl_reset_n && sweep_pos >= 0 && sweep_pos < DEPTH;
    e.done = ctrl_reset_n && sweep_pos == DEPTH;
    exp_q.push_back(e);
  endfunction

  // One clock cycle: drive the inputs, queue the expected outputs, then let
  // the edge happen and update the model.
  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic clr);
    ctrl_writeEnable = we;
    ctrl_writeReg    = wa;
    data_writeReg    = wd;
    ctrl_readRegA    = ra;
    ctrl_readRegB    = rb;
    ctrl_clear       = clr;
    push_expect();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic rand_step(input int clr_one_in);
    step(1'($urandom), AW'($urandom), $urandom, AW'($urandom), AW'($urandom),
         ($urandom % clr_one_in) == 0);
  endtask

  // Reset is already low. Hold it for 32 cycles with random writes and
  // clears while every address is read back, then release it between edges.
  task automatic reset_hold();
    for (int k = 0; k < DEPTH; k++)
      step(1'($urandom), AW'($urandom), $urandom, AW'(k), AW'(DEPTH - 1 - k), 1'($urandom));
    #1 ctrl_reset_n = 1'b1;
  endtask

  task automatic fill_regs();
    for (int i = 1; i < DEPTH; i++)
      step(1'b1, AW'(i), $urandom | 32'h1, AW'($urandom), AW'($urandom), 1'b0);
  endtask

  // Monitor: on each falling edge, compare the outputs with the oldest queued expectation.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("rdA_z1", rd_a0, mon_e.a0);
      check("rdB_z1", rd_b0, mon_e.b0);
      check("rdA_z0", rd_a1, mon_e.a1);
      check("rdB_z0", rd_b1, mon_e.b1);
      check("busy_z1", {31'd0, busy0}, {31'd0, mon_e.busy});
      check("done_z1", {31'd0, done0}, {31'd0, mon_e.done});
      check("busy_z0", {31'd0, busy1}, {31'd0, mon_e.busy});
      check("done_z0", {31'd0, done1}, {31'd0, mon_e.done});
    end
  end

  initial begin
    ctrl_reset_n     = 1'b0;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = '0;
    data_writeReg    = '0;
    ctrl_readRegA    = '0;
    ctrl_readRegB    = '0;
    ctrl_clear       = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    reset_hold();

    // Basic write and read-back on both ports.
    step(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 1'b0);
    step(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0);

    // Write to entry 0: inst0 must read zero, inst1 must return the data.
    step(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd5, 1'b0);
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);

    // Same-cycle read of the entry being written (forwarding when enabled).
    step(1'b1, 5'd7, 32'h00000001, 5'd3, 5'd7, 1'b0);
    step(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd0, 1'b0);
    step(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0);

    // Full sweep. The write to reg 31 in the third sweep cycle is dropped.
    // Clear requests during CLEAR and DONE are ignored.
    fill_regs();
    step(1'b0, 5'd0, 32'h0, 5'd31, 5'd1, 1'b1);
    for (int k = 0; k < DEPTH + 2; k++) begin
      if (k == 2)
        step(1'b1, 5'd31, 32'hBAD00031, 5'd31, AW'($urandom), 1'b0);
      else
        step(1'b0, 5'd0, 32'h0, AW'($urandom), AW'(k), (k == 5) || (k == DEPTH));
    end
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 5'd0, 32'h0, AW'(i), AW'(DEPTH - 1 - i), 1'b0);

    // Clear and write on the same edge: reg 2 keeps 0xFF until its sweep slot.
    fill_regs();
    step(1'b1, 5'd2, 32'h000000FF, 5'd2, 5'd31, 1'b1);
    for (int k = 0; k < DEPTH + 2; k++)
      step(1'b0, 5'd0, 32'h0, 5'd2, 5'd31, 1'b0);

    // Reset asserted between edges in sweep cycle 10. The outputs must clear
    // before the next rising edge, and no completion pulse may follow.
    fill_regs();
    step(1'b0, 5'd0, 32'h0, 5'd20, 5'd3, 1'b1);
    for (int k = 0; k < 10; k++)
      step(1'b0, 5'd0, 32'h0, 5'd20, AW'(k), 1'b0);
    #1 ctrl_reset_n = 1'b0;
    model_reset();
    reset_hold();
    step(1'b1, 5'd9, 32'h55AA55AA, 5'd9, 5'd20, 1'b0);
    for (int k = 0; k < 40; k++)
      step(1'b0, 5'd0, 32'h0, 5'd9, AW'(k), 1'b0);

    // Random traffic with occasional clear requests.
    for (int k = 0; k < 600; k++) rand_step(40);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
